led_code_sequencer: RTL

Board-level status LED driver sitting directly downstream of the heartbeat indicator. It consumes the indicator's slow toggling LED level and either passes it through or overrides it with a repeating blink code: N pulses, then a long gap. A status code is loaded over a valid/ready handshake from the Nios II PIO. All LED output is brightness-scaled by an 8-bit PWM duty.

---
 rtl/led_seq_pkg.sv | 29 ++
 rtl/led_pwm.sv | 27 ++
 rtl/led_code_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and sizing helpers for the status-LED blink-code sequencer.
// Imported by the top-level sequencer and by its PWM sub-module.
package led_seq_pkg;

    localparam int CODE_W = 4;
    localparam int DUTY_W = 8;
    localparam int MS_CNT_MIN_W = 11;

    typedef enum logic [1:0] {
        ST_HEART     = 2'd0,
        ST_PULSE_ON  = 2'd1,
        ST_PULSE_OFF = 2'd2,
        ST_GAP       = 2'd3
    } seq_state_e;

    function automatic int cycles_per_ms(input int freq);
        return freq / 1000;
    endfunction

    // Wide enough for the larger of the two phase lengths, never below the minimum.
    function automatic int ms_cnt_width(input int pulse_ms, input int gap_ms);
        int longest;
        int w;
        longest = (pulse_ms > gap_ms) ? pulse_ms : gap_ms;
        w = $clog2(longest + 1);
        return (w > MS_CNT_MIN_W) ? w : MS_CNT_MIN_W;
    endfunction

endpackage

// File: rtl/led_pwm.sv
// Free-running 8-bit brightness PWM; full scale (duty 0xFF) is forced solid on
// so that maximum brightness never shows the one-cycle dropout of a plain compare.
module led_pwm
    import led_seq_pkg::*;
(
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic [DUTY_W-1:0] duty_i,
    output logic              pwm_o
);

    logic [DUTY_W-1:0] pcnt_q;
    logic [DUTY_W-1:0] pcnt_d;

    assign pcnt_d = pcnt_q + DUTY_W'(1);

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign pwm_o = (pcnt_q < duty_i) | (duty_i == '1);

endmodule

// File: rtl/led_code_sequencer.sv
// Status LED driver: passes the heartbeat through, or overrides it with a
// repeating N-pulse blink code loaded over a valid/ready handshake.
//
//   state        | meaning
//   -------------+---------------------------------------------------------
//   ST_HEART     | heartbeat passthrough, code accepted (0 is a no-op)
//   ST_PULSE_ON  | LED lit for PULSE_MS, handshake closed
//   ST_PULSE_OFF | LED dark for PULSE_MS, then next pulse or gap
//   ST_GAP       | LED dark for GAP_MS, then code repeats; new code accepted
module led_code_sequencer
    import led_seq_pkg::*;
#(
    parameter int FREQ     = 100_000_000,
    parameter int PULSE_MS = 200,
    parameter int GAP_MS   = 1000
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iBEAT,
    input  logic [CODE_W-1:0] iCODE,
    input  logic              iCODE_VALID,
    output logic              oCODE_READY,
    input  logic [DUTY_W-1:0] iDUTY,
    output logic              oLED,
    output logic              oBUSY
);

    localparam int CPM   = cycles_per_ms(FREQ);
    localparam int PRE_W = $clog2(CPM);
    localparam int MS_W  = ms_cnt_width(PULSE_MS, GAP_MS);

    localparam logic [PRE_W-1:0] PRE_TC     = PRE_W'(CPM - 1);
    localparam logic [MS_W-1:0]  PULSE_LAST = MS_W'(PULSE_MS - 1);
    localparam logic [MS_W-1:0]  GAP_LAST   = MS_W'(GAP_MS - 1);

    seq_state_e        state_q;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] remain_q;
    logic              led_q;
    logic [PRE_W-1:0]  pre_q;
    logic [PRE_W-1:0]  pre_d;
    logic [MS_W-1:0]   ms_q;
    logic [MS_W-1:0]   ms_d;

    logic pwm;
    logic accept;
    logic code_nz;
    logic tick;
    logic pulse_done;
    logic gap_done;
    logic state_chg;
    logic led_req;

    led_pwm u_pwm (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .duty_i (iDUTY),
        .pwm_o  (pwm)
    );

    assign oCODE_READY = (state_q == ST_HEART) | (state_q == ST_GAP);
    assign oBUSY       = (state_q != ST_HEART);
    assign oLED        = led_q;

    assign accept     = iCODE_VALID & oCODE_READY;
    assign code_nz    = (iCODE != '0);
    assign tick       = (pre_q == PRE_TC);
    assign pulse_done = tick & (ms_q == PULSE_LAST);
    assign gap_done   = tick & (ms_q == GAP_LAST);

    // Mirrors every transition taken by the FSM below so the timers restart in step.
    always_comb begin
        state_chg = 1'b0;
        case (state_q)
            ST_HEART:     state_chg = accept & code_nz;
            ST_PULSE_ON:  state_chg = pulse_done;
            ST_PULSE_OFF: state_chg = pulse_done;
            ST_GAP:       state_chg = accept | gap_done;
            default:      state_chg = 1'b1;
        endcase
    end

    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        ms_d  = ms_q;
        if (state_q == ST_HEART || state_chg) begin
            pre_d = '0;
            ms_d  = '0;
        end else if (tick) begin
            pre_d = '0;
            ms_d  = ms_q + MS_W'(1);
        end
    end

    always_comb begin
        led_req = 1'b0;
        case (state_q)
            ST_HEART:    led_req = iBEAT & pwm;
            ST_PULSE_ON: led_req = pwm;
            default:     led_req = 1'b0;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            pre_q <= '0;
            ms_q  <= '0;
        end else begin
            pre_q <= pre_d;
            ms_q  <= ms_d;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q  <= ST_HEART;
            code_q   <= '0;
            remain_q <= '0;
            led_q    <= 1'b0;
        end else begin
            led_q <= led_req;
            case (state_q)
                ST_HEART: begin
                    if (accept && code_nz) begin
                        code_q   <= iCODE;
                        remain_q <= iCODE;
                        state_q  <= ST_PULSE_ON;
                    end
                end
                ST_PULSE_ON: begin
                    if (pulse_done) begin
                        state_q <= ST_PULSE_OFF;
                    end
                end
                ST_PULSE_OFF: begin
                    if (pulse_done) begin
                        if (remain_q == CODE_W'(1)) begin
                            state_q <= ST_GAP;
                        end else begin
                            remain_q <= remain_q - CODE_W'(1);
                            state_q  <= ST_PULSE_ON;
                        end
                    end
                end
                ST_GAP: begin
                    // A freshly offered code overrides the repeat of the old one.
                    if (accept) begin
                        if (code_nz) begin
                            code_q   <= iCODE;
                            remain_q <= iCODE;
                            state_q  <= ST_PULSE_ON;
                        end else begin
                            state_q <= ST_HEART;
                        end
                    end else if (gap_done) begin
                        remain_q <= code_q;
                        state_q  <= ST_PULSE_ON;
                    end
                end
                default: begin
                    state_q <= ST_HEART;
                end
            endcase
        end
    end

endmodule
